// File: rtl/mux8way16_rr_arbiter.sv
// Round-robin arbiter sharing one 8-way x16 mux, with a one-entry registered valid/ready output stage.
// Define ARB_BURST_EN to let a granted requester hold the grant for up to BURST_LEN consecutive beats.
module mux8way16_rr_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  input  logic [15:0] d_i,
  input  logic [15:0] e_i,
  input  logic [15:0] f_i,
  input  logic [15:0] g_i,
  input  logic [15:0] h_i,
  input  logic [7:0]  req_valid_i,
  output logic [7:0]  req_ready_o,
  output logic        out_valid_o,
  output logic [15:0] out_data_o,
  output logic [2:0]  out_sel_o,
  input  logic        out_ready_i
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [15:0]  data_q, data_d;
  logic [2:0]   sel_q, sel_d;

  logic [127:0] word_bus;
  logic [15:0]  words [8];
  logic [15:0]  req_dbl;
  logic [7:0]   req_rot;
  logic [2:0]   grant_off;
  logic [2:0]   grant_id;
  logic         load;

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("BURST_LEN must be in 1..15");
  end

  assign word_bus = {h_i, g_i, f_i, e_i, d_i, c_i, b_i, a_i};
  for (genvar gi = 0; gi < 8; gi++) begin : g_words
    assign words[gi] = word_bus[gi*16 +: 16];
  end

  assign load = (~out_valid_o | out_ready_i) & (|req_valid_i);

  // Rotate requests so bit 0 is the pointer position; the lowest set bit then wins.
  assign req_dbl = {req_valid_i, req_valid_i};
  assign req_rot = req_dbl[ptr_q +: 8];

  always_comb begin
    grant_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) grant_off = 3'(i);
    end
  end

  assign grant_id    = ptr_q + grant_off;
  assign req_ready_o = (load && rst_n_i) ? (8'd1 << grant_id) : 8'd0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      data_d = words[grant_id];
      sel_d  = grant_id;
    end
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready_i && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

`ifdef ARB_BURST_EN
  localparam logic [3:0] BURST_LEN_C = 4'(BURST_LEN);

  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] beats;

  always_comb begin
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    beats       = burst_cnt_q;
    if (load) begin
      // A grant on the locked id extends the burst; any other grant starts a new one.
      beats = (grant_id == ptr_q) ? burst_cnt_q + 4'd1 : 4'd1;
      if (beats >= BURST_LEN_C) begin
        ptr_d       = grant_id + 3'd1;
        burst_cnt_d = 4'd0;
      end else begin
        ptr_d       = grant_id;
        burst_cnt_d = beats;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) burst_cnt_q <= 4'd0;
    else          burst_cnt_q <= burst_cnt_d;
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = grant_id + 3'd1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      ptr_q   <= 3'd0;
      data_q  <= 16'h0000;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;

endmodule

// File: tb/tb_mux8way16_rr_arbiter.sv
// Scoreboard bench for mux8way16_rr_arbiter: directed round-robin/backpressure/wrap/sparse cases plus random traffic.
// Reference model follows ARB_BURST_EN the same way the design does.
module tb_mux8way16_rr_arbiter;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] w [8];
  logic [7:0]  req_valid;
  logic [7:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_sel;

  always #5 clk = ~clk;

  mux8way16_rr_arbiter #(.BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_i(w[0]), .b_i(w[1]), .c_i(w[2]), .d_i(w[3]),
    .e_i(w[4]), .f_i(w[5]), .g_i(w[6]), .h_i(w[7]),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_sel_o(out_sel),
    .out_ready_i(out_ready)
  );

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
  } item_t;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];

  // Reference model state: scan start, beats held by the current owner, and the output register contents.
  int          m_ptr;
  int          m_beats;
  bit          m_valid;
  logic [15:0] m_data;
  logic [2:0]  m_sel;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_beats = 0; m_valid = 0; m_data = 16'h0000; m_sel = 3'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 8'hFF; out_ready = 1'b1;
    for (int n = 0; n < 8; n++) w[n] = 16'($urandom);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_sel", 32'(out_sel), 32'h0);
      @(negedge clk); #1;
    end
    model_reset();
    req_valid = 8'h00;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: drive inputs, predict the grant, check and update the model before the edge.
  task automatic cycle(input logic [7:0] req, input logic rdy, input bit pattern, output int gid);
    item_t it;
    @(negedge clk);
    req_valid = req;
    out_ready = rdy;
    for (int n = 0; n < 8; n++) w[n] = pattern ? 16'hA000 + 16'(n) : 16'($urandom);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    gid = -1;
    if ((!m_valid || rdy) && req != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        if (gid < 0 && req[(m_ptr + k) % 8]) gid = (m_ptr + k) % 8;
      end
    end
    chk("req_ready", 32'(req_ready), (gid < 0) ? 32'h0 : (32'h1 << gid));
    if (gid >= 0) begin
      it.sel = 3'(gid);
      it.data = w[gid];
      exp_q.push_back(it);
      m_valid = 1; m_data = w[gid]; m_sel = 3'(gid);
`ifdef ARB_BURST_EN
      if (gid == m_ptr) m_beats++;
      else m_beats = 1;
      if (m_beats >= BL) begin
        m_ptr = (gid + 1) % 8;
        m_beats = 0;
      end else begin
        m_ptr = gid;
      end
`else
      m_ptr = (gid + 1) % 8;
`endif
    end else if (rdy) begin
      m_valid = 0;
    end
  endtask

  // Monitor: pops the scoreboard whenever an output transfer is about to occur.
  initial begin
    item_t it;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got sel=%0d data=%h expected no word", out_sel, out_data);
        end else begin
          it = exp_q.pop_front();
          chk("sb_data", 32'(out_data), 32'(it.data));
          chk("sb_sel", 32'(out_sel), 32'(it.sel));
          $display("xfer sel=%0d data=%h", out_sel, out_data);
        end
      end
    end
  end

  initial begin
    int g;
    int expg;
    logic [7:0] rq;
    rst_n = 1'b0; req_valid = 8'hFF; out_ready = 1'b0;
    for (int n = 0; n < 8; n++) w[n] = 16'h0000;
    model_reset();
    do_reset();

    // Round-robin with every requester valid and a free-running sink.
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, 1'b1, 1'b1, g);
`ifdef ARB_BURST_EN
      expg = i / BL;
`else
      expg = i % 8;
`endif
      chk("rr_grant", 32'(req_ready), 32'h1 << expg);
    end

    // Backpressure: nothing accepted while the held word is stuck.
    for (int i = 0; i < 3; i++) begin
      cycle(8'hFF, 1'b0, 1'b1, g);
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    cycle(8'hFF, 1'b1, 1'b1, g);

`ifndef ARB_BURST_EN
    // Wrap: a grant to id5 leaves the pointer at 6.
    cycle(8'h20, 1'b1, 1'b0, g);
    cycle(8'h03, 1'b1, 1'b0, g);
    chk("wrap_id0", 32'(req_ready), 32'h01);
    cycle(8'h03, 1'b1, 1'b0, g);
    chk("wrap_id1", 32'(req_ready), 32'h02);
`endif

    // Sparse/empty then a lone requester on id5.
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, 1'b0, g);
    cycle(8'h20, 1'b1, 1'b0, g);
    chk("sparse_id5", 32'(req_ready), 32'h20);

`ifdef ARB_BURST_EN
    // Burst lock break: id1 drops after two beats, next grant goes to id2.
    do_reset();
    for (int i = 0; i < BL + 2; i++) cycle(8'hFF, 1'b1, 1'b1, g);
    cycle(8'hFD, 1'b1, 1'b1, g);
    chk("burst_break", 32'(req_ready), 32'h04);
`endif

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      case ($urandom_range(0, 3))
        0:       rq = 8'h00;
        1:       rq = 8'(1 << $urandom_range(0, 7));
        default: rq = 8'($urandom);
      endcase
      cycle(rq, ($urandom_range(0, 3) != 0), 1'b0, g);
    end

    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b1, 1'b0, g);
    @(negedge clk); #3;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
